// File: rtl/gppcu_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// gppcu_cmd_sequencer
//
// Upstream driver for the GPPCU instruction-queue test block. Host
// command/data pairs arrive over a valid/ready channel and are buffered in a
// small FIFO. Each entry is then replayed onto the queue's command and data
// buses. Bit 31 of the command bus carries a strobe that the sequencer
// generates. The strobe is framed by SETUP_CYC stable-low cycles before and
// after a HIGH_CYC high phase. Read-back data (wparam 1 and 4) and the result
// of the local wait-for-done pseudo-op (wparam 5) come back on a valid/ready
// response channel.
//
// Ports
//   iACLK       in   1   sole clock
//   inRST       in   1   synchronous active-low reset
//   iCMD_VALID  in   1   host command valid
//   oCMD_READY  out  1   FIFO not full (low while in reset)
//   iCMD_WORD   in  32   [30:24] wparam, [23:16] lparam, [15:0] command;
//                        bit 31 is ignored
//   iCMD_DATA   in  32   data paired with the command
//   oRSP_VALID  out  1   response valid
//   iRSP_READY  in   1   host accepts the response
//   oRSP_DATA   out 32   read data, or {done, zeros, count} for wait-done
//   oQ_CMD      out 32   queue command bus; bit 31 is the generated strobe
//   oQ_DATA     out 32   queue data bus
//   iQ_DATA     in  32   queue read-back data
//   iQ_DONE     in   1   queue done flag
//   oBUSY       out  1   FIFO non-empty or sequencer not idle
// ----------------------------------------------------------------------------
module gppcu_cmd_sequencer #(
  parameter int SETUP_CYC = 2,   // stable-low cycles around the strobe (>= 1)
  parameter int HIGH_CYC  = 2,   // strobe high cycles (>= 1)
  parameter int FIFO_AW   = 3,   // log2 of command FIFO depth (>= 1)
  parameter int TO_BW     = 16   // wait-done timeout counter width (<= 31)
) (
  input  logic        iACLK,
  input  logic        inRST,
  input  logic        iCMD_VALID,
  output logic        oCMD_READY,
  input  logic [31:0] iCMD_WORD,
  input  logic [31:0] iCMD_DATA,
  output logic        oRSP_VALID,
  input  logic        iRSP_READY,
  output logic [31:0] oRSP_DATA,
  output logic [31:0] oQ_CMD,
  output logic [31:0] oQ_DATA,
  input  logic [31:0] iQ_DATA,
  input  logic        iQ_DONE,
  output logic        oBUSY
);

  localparam int DEPTH    = 1 << FIFO_AW;
  localparam int STEP_MAX = (SETUP_CYC > HIGH_CYC) ? SETUP_CYC : HIGH_CYC;
  localparam int STEP_BW  = $clog2(STEP_MAX + 1);
  // One counter serves both the phase timer and the wait-done counter.
  localparam int CNT_BW   = (TO_BW > STEP_BW) ? TO_BW : STEP_BW;

  localparam logic [6:0] WP_READ  = 7'd1;
  localparam logic [6:0] WP_RUN   = 7'd4;
  localparam logic [6:0] WP_WAITD = 7'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_HOLD,
    S_WAITD,
    S_RESP
  } state_e;

  // --------------------------------------------------------------------------
  // Command FIFO: 64-bit entries {command word, data}
  // --------------------------------------------------------------------------
  logic [63:0]        fifo_mem_q [DEPTH];
  logic [FIFO_AW:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0]   rd_ptr_q, rd_ptr_d;
  logic               fifo_empty;
  logic               fifo_full;
  logic               fifo_push;
  logic               fifo_pop;
  logic [63:0]        fifo_head;

  // The extra pointer bit tells full from empty when the index bits match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                      (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);

  // Ready is forced low while reset is held so nothing is accepted then.
  assign oCMD_READY = inRST & ~fifo_full;
  assign fifo_push  = iCMD_VALID & oCMD_READY;
  assign fifo_head  = fifo_mem_q[rd_ptr_q[FIFO_AW-1:0]];

  assign wr_ptr_d = fifo_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = fifo_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of block order.
  always_ff @(posedge iACLK) begin
    if (!inRST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: the storage array has no reset; emptiness is defined by the
  // pointers alone, so clearing it would only cost reset fan-out.
  always_ff @(posedge iACLK) begin
    if (fifo_push) begin
      fifo_mem_q[wr_ptr_q[FIFO_AW-1:0]] <= {iCMD_WORD, iCMD_DATA};
    end
  end

  // The host's bit 31 is replaced by the generated strobe and never used.
  logic unused_host_bit31;
  assign unused_host_bit31 = fifo_head[63];

  // --------------------------------------------------------------------------
  // Sequencer FSM
  // --------------------------------------------------------------------------
  state_e             state_q, state_d;
  logic [CNT_BW-1:0]  cnt_q, cnt_d;
  logic [30:0]        cmd_q, cmd_d;
  logic [31:0]        data_q, data_d;
  logic [31:0]        rsp_data_q, rsp_data_d;
  logic               strobe_q, strobe_d;
  logic [TO_BW-1:0]   wait_cnt;
  logic [31:0]        wait_rsp;

  assign wait_cnt = cnt_q[TO_BW-1:0];
  // Wait result without the done flag: {0, zeros, count}.
  assign wait_rsp = {{(32-TO_BW){1'b0}}, wait_cnt};

  // NOTE: every signal assigned below gets a default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    data_d     = data_q;
    rsp_data_d = rsp_data_q;
    fifo_pop   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cmd_d    = fifo_head[62:32];
          data_d   = fifo_head[31:0];
          if (fifo_head[62:56] == WP_WAITD) begin
            state_d = S_WAITD;
            cnt_d   = '0;
          end else begin
            state_d = S_SETUP;
            cnt_d   = CNT_BW'(SETUP_CYC - 1);
          end
        end
      end

      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_HIGH;
          cnt_d   = CNT_BW'(HIGH_CYC - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_HIGH: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = CNT_BW'(SETUP_CYC - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_HOLD: begin
        if (cnt_q == '0) begin
          // Read-back is sampled on the last hold cycle, after the queue has
          // had the full hold time to present its data.
          if (cmd_q[30:24] == WP_READ || cmd_q[30:24] == WP_RUN) begin
            rsp_data_d = iQ_DATA;
            state_d    = S_RESP;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_WAITD: begin
        // Done is tested first so it wins over a simultaneous timeout.
        if (iQ_DONE) begin
          rsp_data_d     = wait_rsp;
          rsp_data_d[31] = 1'b1;
          state_d        = S_RESP;
        end else if (&wait_cnt) begin
          rsp_data_d = wait_rsp;
          state_d    = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_BW'(1);
        end
      end

      S_RESP: begin
        if (iRSP_READY) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // The strobe is registered from the next state so it is glitch-free and
  // lines up exactly with the HIGH phase.
  assign strobe_d = (state_d == S_HIGH);

  always_ff @(posedge iACLK) begin
    if (!inRST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cmd_q      <= '0;
      data_q     <= '0;
      rsp_data_q <= '0;
      strobe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      data_q     <= data_d;
      rsp_data_q <= rsp_data_d;
      strobe_q   <= strobe_d;
    end
  end

  assign oQ_CMD     = {strobe_q, cmd_q};
  assign oQ_DATA    = data_q;
  assign oRSP_VALID = (state_q == S_RESP);
  assign oRSP_DATA  = rsp_data_q;
  assign oBUSY      = ~fifo_empty | (state_q != S_IDLE);

endmodule

// File: tb/tb_gppcu_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// tb_gppcu_cmd_sequencer
//
// Directed bench for gppcu_cmd_sequencer. Instance dut_a uses the default
// parameters; dut_b uses TO_BW=4 so the wait-done timeout is reachable.
// A strobe monitor records every pulse (command, data, width, gap), and a
// small queue stand-in raises done some cycles after a RUN command is strobed.
// ----------------------------------------------------------------------------
module tb_gppcu_cmd_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;

  // dut_a signals
  logic        a_cmd_valid = 1'b0;
  logic        a_cmd_ready;
  logic [31:0] a_cmd_word = '0;
  logic [31:0] a_cmd_data = '0;
  logic        a_rsp_valid;
  logic        a_rsp_ready = 1'b0;
  logic [31:0] a_rsp_data;
  logic [31:0] a_q_cmd;
  logic [31:0] a_q_data;
  logic [31:0] a_q_rdata = '0;
  logic        a_q_done;
  logic        a_busy;
  logic        tb_done = 1'b0;
  logic        prog_done = 1'b0;

  assign a_q_done = tb_done | prog_done;

  // dut_b signals
  logic        b_cmd_valid = 1'b0;
  logic        b_cmd_ready;
  logic [31:0] b_cmd_word = '0;
  logic [31:0] b_cmd_data = '0;
  logic        b_rsp_valid;
  logic        b_rsp_ready = 1'b0;
  logic [31:0] b_rsp_data;
  logic [31:0] b_q_cmd;
  logic [31:0] b_q_data;
  logic [31:0] b_q_rdata = '0;
  logic        b_q_done = 1'b0;
  logic        b_busy;

  gppcu_cmd_sequencer dut_a (
    .iACLK      (clk),
    .inRST      (rst_n),
    .iCMD_VALID (a_cmd_valid),
    .oCMD_READY (a_cmd_ready),
    .iCMD_WORD  (a_cmd_word),
    .iCMD_DATA  (a_cmd_data),
    .oRSP_VALID (a_rsp_valid),
    .iRSP_READY (a_rsp_ready),
    .oRSP_DATA  (a_rsp_data),
    .oQ_CMD     (a_q_cmd),
    .oQ_DATA    (a_q_data),
    .iQ_DATA    (a_q_rdata),
    .iQ_DONE    (a_q_done),
    .oBUSY      (a_busy)
  );

  gppcu_cmd_sequencer #(.TO_BW(4)) dut_b (
    .iACLK      (clk),
    .inRST      (rst_n),
    .iCMD_VALID (b_cmd_valid),
    .oCMD_READY (b_cmd_ready),
    .iCMD_WORD  (b_cmd_word),
    .iCMD_DATA  (b_cmd_data),
    .oRSP_VALID (b_rsp_valid),
    .iRSP_READY (b_rsp_ready),
    .oRSP_DATA  (b_rsp_data),
    .oQ_CMD     (b_q_cmd),
    .oQ_DATA    (b_q_data),
    .iQ_DATA    (b_q_rdata),
    .iQ_DONE    (b_q_done),
    .oBUSY      (b_busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [31:0] w, input logic [31:0] d);
    int   n;
    logic rdy;
    n = 0;
    a_cmd_valid = 1'b1;
    a_cmd_word  = w;
    a_cmd_data  = d;
    do begin
      rdy = a_cmd_ready;
      step();
      n++;
    end while (!rdy && n < 50);
    a_cmd_valid = 1'b0;
    check("push_accepted", {31'b0, rdy}, 32'd1);
  endtask

  task automatic wait_idle_a(input string tag, input int budget);
    int n;
    n = 0;
    while (a_busy && n < budget) begin
      step();
      n++;
    end
    check(tag, {31'b0, a_busy}, 32'd0);
  endtask

  task automatic wait_rsp_a(input int budget, output int n);
    n = 0;
    while (!a_rsp_valid && n < budget) begin
      step();
      n++;
    end
  endtask

  // --------------------------------------------------------------------------
  // Strobe monitor on dut_a (sampled on the falling edge)
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic [30:0] cmd;
    logic [31:0] data;
  } pulse_t;

  pulse_t      mon_q[$];
  int          hi_cnt    = 0;
  int          lo_cnt    = 0;
  int          min_gap   = 1000;
  int          bad_width = 0;
  int          viol      = 0;
  logic        seen      = 1'b0;
  logic        prev_s    = 1'b0;
  logic [30:0] prev_cmd  = '0;

  always @(negedge clk) begin
    prev_s   <= a_q_cmd[31];
    prev_cmd <= a_q_cmd[30:0];
    if (!rst_n) begin
      hi_cnt <= 0;
      lo_cnt <= 0;
      seen   <= 1'b0;
      prev_s <= 1'b0;
    end else if (a_q_cmd[31]) begin
      if (!prev_s) begin
        mon_q.push_back('{a_q_cmd[30:0], a_q_data});
        if (seen && lo_cnt < min_gap) min_gap <= lo_cnt;
        seen   <= 1'b1;
        hi_cnt <= 1;
      end else begin
        hi_cnt <= hi_cnt + 1;
        if (a_q_cmd[30:0] != prev_cmd) viol <= viol + 1;
      end
    end else begin
      if (prev_s) begin
        if (hi_cnt != 2) bad_width <= bad_width + 1;
        lo_cnt <= 1;
      end else begin
        lo_cnt <= lo_cnt + 1;
      end
    end
  end

  // Queue stand-in: a strobed RUN (wp=4, cmd=1) finishes 20 cycles later and
  // its done flag stays high until the next RUN or a reset.
  int   run_cnt = 0;
  logic q_prev  = 1'b0;

  always @(posedge clk) begin
    q_prev <= a_q_cmd[31];
    if (!rst_n) begin
      run_cnt   <= 0;
      prog_done <= 1'b0;
    end else if (a_q_cmd[31] && !q_prev && a_q_cmd[30:24] == 7'd4 && a_q_cmd[15:0] == 16'd1) begin
      run_cnt   <= 20;
      prog_done <= 1'b0;
    end else if (run_cnt != 0) begin
      run_cnt <= run_cnt - 1;
      if (run_cnt == 1) prog_done <= 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  logic [31:0] t1_exp [7] = '{32'h0201_0005, 32'h0201_0005, 32'h8201_0005,
                              32'h8201_0005, 32'h0201_0005, 32'h0201_0005,
                              32'h0201_0005};

  initial begin
    int          n;
    int          acc;
    int          cyc;
    int          first_low;
    int          rises;
    logic        rdy;
    logic [30:0] exp_cmd;

    // ---- reset state ----
    repeat (3) step();
    check("rst_q_cmd",     a_q_cmd,     32'h0);
    check("rst_q_data",    a_q_data,    32'h0);
    check("rst_rsp_valid", {31'b0, a_rsp_valid}, 32'd0);
    check("rst_rsp_data",  a_rsp_data,  32'h0);
    check("rst_busy",      {31'b0, a_busy},      32'd0);
    check("rst_ready_low", {31'b0, a_cmd_ready}, 32'd0);
    rst_n = 1'b1;
    step();
    check("ready_after_rst", {31'b0, a_cmd_ready}, 32'd1);
    check("busy_after_rst",  {31'b0, a_busy},      32'd0);

    // ---- strobed write, no response ----
    push_a(32'h0201_0005, 32'h0000_1234);
    for (int i = 0; i < 7; i++) begin
      step();
      check($sformatf("t1_q_cmd[%0d]", i), a_q_cmd, t1_exp[i]);
      check($sformatf("t1_q_data[%0d]", i), a_q_data, 32'h0000_1234);
      check($sformatf("t1_no_rsp[%0d]", i), {31'b0, a_rsp_valid}, 32'd0);
    end
    check("t1_busy_done", {31'b0, a_busy}, 32'd0);

    // ---- read with stalled response ----
    a_q_rdata = 32'hCAFE_0001;
    push_a(32'h0122_0033, 32'h0000_0055);
    wait_rsp_a(20, n);
    check("t2_rsp_latency", n, 32'd7);
    a_q_rdata = 32'hDEAD_0000;
    push_a(32'h0200_0077, 32'h0000_0066);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("t2_rsp_valid[%0d]", i), {31'b0, a_rsp_valid}, 32'd1);
      check($sformatf("t2_rsp_data[%0d]", i), a_rsp_data, 32'hCAFE_0001);
      check($sformatf("t2_no_next[%0d]", i), a_q_cmd, 32'h0122_0033);
    end
    a_rsp_ready = 1'b1;
    step();
    a_rsp_ready = 1'b0;
    check("t2_rsp_dropped", {31'b0, a_rsp_valid}, 32'd0);
    step();
    check("t2_next_started", a_q_cmd, 32'h0200_0077);
    check("t2_next_data", a_q_data, 32'h0000_0066);
    wait_idle_a("t2_idle", 50);

    // ---- burst with valid held high ----
    mon_q.delete();
    acc       = 0;
    cyc       = 0;
    first_low = -1;
    a_cmd_valid = 1'b1;
    a_cmd_word  = {1'b1, 7'(acc + 6), 8'(acc), 16'(acc + 256)};
    a_cmd_data  = 32'hD000_0000 + 32'(acc);
    while (acc < 11 && cyc < 200) begin
      rdy = a_cmd_ready;
      step();
      cyc++;
      if (rdy) begin
        acc++;
        a_cmd_word = {1'b1, 7'(acc + 6), 8'(acc), 16'(acc + 256)};
        a_cmd_data = 32'hD000_0000 + 32'(acc);
      end
      if (!a_cmd_ready && first_low < 0) first_low = acc;
    end
    a_cmd_valid = 1'b0;
    check("t3_accepted", acc, 32'd11);
    check("t3_ready_drop_at", first_low, 32'd10);
    check("t3_cycles", cyc, 32'd17);
    wait_idle_a("t3_idle", 300);
    check("t3_pulses", mon_q.size(), 32'd11);
    for (int i = 0; i < 11; i++) begin
      exp_cmd = {7'(i + 6), 8'(i), 16'(i + 256)};
      if (i < mon_q.size()) begin
        check($sformatf("t3_cmd[%0d]", i), {1'b0, mon_q[i].cmd}, {1'b0, exp_cmd});
        check($sformatf("t3_data[%0d]", i), mon_q[i].data, 32'hD000_0000 + 32'(i));
      end
    end

    // ---- wait-done, done after 37 cycles ----
    push_a(32'h0500_0000, 32'h0);
    step();
    check("t4_waitd_cmd", a_q_cmd, 32'h0500_0000);
    repeat (37) step();
    check("t4_no_rsp_yet", {31'b0, a_rsp_valid}, 32'd0);
    tb_done = 1'b1;
    step();
    tb_done = 1'b0;
    check("t4_rsp_valid", {31'b0, a_rsp_valid}, 32'd1);
    check("t4_rsp_data", a_rsp_data, 32'h8000_0025);
    a_rsp_ready = 1'b1;
    step();
    a_rsp_ready = 1'b0;
    check("t4_rsp_done", {31'b0, a_rsp_valid}, 32'd0);

    // ---- wait-done timeout and done-wins on dut_b (TO_BW=4) ----
    check("tb_b_ready", {31'b0, b_cmd_ready}, 32'd1);
    b_cmd_valid = 1'b1;
    b_cmd_word  = 32'h0500_0000;
    step();
    b_cmd_valid = 1'b0;
    repeat (16) step();
    check("t4b_no_rsp_at_14", {31'b0, b_rsp_valid}, 32'd0);
    step();
    check("t4b_timeout_valid", {31'b0, b_rsp_valid}, 32'd1);
    check("t4b_timeout_data", b_rsp_data, 32'h0000_000F);
    b_rsp_ready = 1'b1;
    step();
    b_rsp_ready = 1'b0;
    check("t4b_rsp_done", {31'b0, b_rsp_valid}, 32'd0);
    b_cmd_valid = 1'b1;
    step();
    b_cmd_valid = 1'b0;
    repeat (16) step();
    b_q_done = 1'b1;
    step();
    b_q_done = 1'b0;
    check("t4b_done_wins_valid", {31'b0, b_rsp_valid}, 32'd1);
    check("t4b_done_wins_data", b_rsp_data, 32'h8000_000F);
    b_rsp_ready = 1'b1;
    step();
    b_rsp_ready = 1'b0;

    // ---- reset during HIGH of the 2nd of 3 queued commands ----
    push_a(32'h0200_0101, 32'h11);
    push_a(32'h0200_0102, 32'h22);
    push_a(32'h0200_0103, 32'h33);
    n = 0;
    while (a_q_cmd != 32'h8200_0102 && n < 40) begin
      step();
      n++;
    end
    check("t5_second_high", a_q_cmd, 32'h8200_0102);
    rst_n = 1'b0;
    step();
    check("t5_rst_q_cmd", a_q_cmd, 32'h0);
    check("t5_rst_q_data", a_q_data, 32'h0);
    check("t5_rst_ready", {31'b0, a_cmd_ready}, 32'd0);
    rst_n = 1'b1;
    step();
    check("t5_busy_after", {31'b0, a_busy}, 32'd0);
    check("t5_ready_after", {31'b0, a_cmd_ready}, 32'd1);
    rises = mon_q.size();
    repeat (30) step();
    check("t5_no_more_strobes", mon_q.size(), rises);
    check("t5_q_cmd_quiet", a_q_cmd, 32'h0);

    // ---- RUN then wait-done against the queue stand-in ----
    a_q_rdata = 32'h0000_0042;
    push_a(32'h0400_0001, 32'h0);
    push_a(32'h0500_0000, 32'h0);
    wait_rsp_a(30, n);
    check("t6_run_rsp_valid", {31'b0, a_rsp_valid}, 32'd1);
    check("t6_run_rsp_data", a_rsp_data, 32'h0000_0042);
    a_rsp_ready = 1'b1;
    step();
    a_rsp_ready = 1'b0;
    wait_rsp_a(100, n);
    check("t6_status_valid", {31'b0, a_rsp_valid}, 32'd1);
    check("t6_status_done", {31'b0, a_rsp_data[31]}, 32'd1);
    a_rsp_ready = 1'b1;
    step();
    a_rsp_ready = 1'b0;
    wait_idle_a("t6_idle", 20);

    // ---- strobe shape over the whole run ----
    check("mon_width", bad_width, 32'd0);
    check("mon_stable_high", viol, 32'd0);
    check("mon_min_gap", min_gap, 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
